// File: rtl/tx_fc_arbiter_if.sv
// Handshake bundle between the TLP source buffers / DLL (master) and the
// credit-gated Tx arbiter (slave).
interface tx_fc_arbiter_if #(
  parameter int FC_HDR_WIDTH  = 12,
  parameter int FC_DATA_WIDTH = 16,
  parameter int LEN_WIDTH     = 10
);
  logic                     p_req;
  logic                     np_req;
  logic                     cpl_req;
  logic                     p_has_data;
  logic                     np_has_data;
  logic                     cpl_has_data;
  logic [LEN_WIDTH-1:0]     p_len;
  logic [LEN_WIDTH-1:0]     np_len;
  logic [LEN_WIDTH-1:0]     cpl_len;
  logic                     np_ro;
  logic                     cpl_ro;
  logic                     fc_upd_valid;
  logic [1:0]               fc_upd_type;
  logic [FC_HDR_WIDTH-1:0]  fc_upd_hdr;
  logic [FC_DATA_WIDTH-1:0] fc_upd_data;
  logic                     tlp_done;
  logic [2:0]               grant;
  logic                     grant_valid;
  logic                     fc_init_done;

  modport master (
    output p_req, np_req, cpl_req,
    output p_has_data, np_has_data, cpl_has_data,
    output p_len, np_len, cpl_len,
    output np_ro, cpl_ro,
    output fc_upd_valid, fc_upd_type, fc_upd_hdr, fc_upd_data,
    output tlp_done,
    input  grant, grant_valid, fc_init_done
  );

  modport slave (
    input  p_req, np_req, cpl_req,
    input  p_has_data, np_has_data, cpl_has_data,
    input  p_len, np_len, cpl_len,
    input  np_ro, cpl_ro,
    input  fc_upd_valid, fc_upd_type, fc_upd_hdr, fc_upd_data,
    input  tlp_done,
    output grant, grant_valid, fc_init_done
  );
endinterface

// File: rtl/tx_fc_arbiter.sv
// Credit-gated round-robin scheduler sharing the Tx datapath among P, NP and CPL.
// Type index 0=P, 1=NP, 2=CPL throughout.
//
// state    | meaning
// ST_INIT  | waiting for InitFC of all three types
// ST_IDLE  | arbitrating among eligible, unblocked requests
// ST_GRANT | one-hot grant held until tlp_done
module tx_fc_arbiter #(
  parameter int FC_HDR_WIDTH  = 12,
  parameter int FC_DATA_WIDTH = 16,
  parameter int LEN_WIDTH     = 10
) (
  input  logic            clk,
  input  logic            arst,
  tx_fc_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_GRANT} state_t;

  localparam logic [FC_HDR_WIDTH-1:0]  HDR_ONE   = FC_HDR_WIDTH'(1);
  localparam logic [FC_HDR_WIDTH-1:0]  HDR_HALF  = {1'b1, {(FC_HDR_WIDTH-1){1'b0}}};
  localparam logic [FC_DATA_WIDTH-1:0] DATA_HALF = {1'b1, {(FC_DATA_WIDTH-1){1'b0}}};

  state_t                   state_q, state_d;
  logic [2:0]               grant_q, grant_d;
  logic                     grant_valid_q;
  logic                     take;
  logic                     found;
  logic [1:0]               pick, idx, rr_q;

  logic [FC_HDR_WIDTH-1:0]  cl_hdr   [3];
  logic [FC_HDR_WIDTH-1:0]  cc_hdr   [3];
  logic [FC_DATA_WIDTH-1:0] cl_data  [3];
  logic [FC_DATA_WIDTH-1:0] cc_data  [3];
  logic [2:0]               init_q, init_d, hdr_inf, data_inf, upd_hit;
  logic                     fc_init_done_q;

  logic [2:0]               req, has_data, elig, cand;
  logic [LEN_WIDTH-1:0]     len      [3];
  logic [LEN_WIDTH:0]       dw_ext   [3];
  logic [FC_DATA_WIDTH-1:0] need_data[3];
  logic [FC_HDR_WIDTH-1:0]  hdr_room [3];
  logic [FC_DATA_WIDTH-1:0] data_room[3];
  logic                     order_block;

  assign req      = {bus.cpl_req, bus.np_req, bus.p_req};
  assign has_data = {bus.cpl_has_data, bus.np_has_data, bus.p_has_data};
  assign len[0]   = bus.p_len;
  assign len[1]   = bus.np_len;
  assign len[2]   = bus.cpl_len;

  assign upd_hit  = bus.fc_upd_valid ? {bus.fc_upd_type == 2'd2,
                                        bus.fc_upd_type == 2'd1,
                                        bus.fc_upd_type == 2'd0} : 3'b000;
  assign init_d   = init_q | upd_hit;

  function automatic logic [1:0] next_type(input logic [1:0] t);
    return (t == 2'd2) ? 2'd0 : t + 2'd1;
  endfunction

  // Room left after this TLP, read modulo 2^W: anything in the upper half
  // means the request would overrun the partner's advertised limit.
  always_comb begin
    for (int t = 0; t < 3; t++) begin
      dw_ext[t]    = (len[t] == '0) ? {1'b1, {LEN_WIDTH{1'b0}}} : {1'b0, len[t]};
      need_data[t] = has_data[t] ? FC_DATA_WIDTH'((dw_ext[t] + (LEN_WIDTH+1)'(3)) >> 2) : '0;
      hdr_room[t]  = cl_hdr[t] - (cc_hdr[t] + HDR_ONE);
      data_room[t] = cl_data[t] - (cc_data[t] + need_data[t]);
      elig[t]      = (hdr_inf[t] || (hdr_room[t] <= HDR_HALF)) &&
                     (data_inf[t] || (data_room[t] <= DATA_HALF));
    end
  end

  // Strictly ordered NP/CPL may not pass a posted TLP that is stuck on credits.
  always_comb begin
    order_block = bus.p_req && !elig[0];
    cand[0]     = req[0] && elig[0];
    cand[1]     = req[1] && elig[1] && (bus.np_ro || !order_block);
    cand[2]     = req[2] && elig[2] && (bus.cpl_ro || !order_block);
  end

  always_comb begin
    found = 1'b0;
    pick  = rr_q;
    idx   = rr_q;
    for (int k = 0; k < 3; k++) begin
      if (!found && cand[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
      idx = next_type(idx);
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    take    = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (fc_init_done_q) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (found) begin
          grant_d = 3'b001 << pick;
          take    = 1'b1;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (bus.tlp_done) begin
          grant_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_INIT;
        grant_d = '0;
      end
    endcase
  end

  // Consumed credits are charged at grant time; rr_q names the type that
  // gets first look at the next arbitration.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      rr_q          <= 2'd0;
      for (int t = 0; t < 3; t++) begin
        cc_hdr[t]  <= '0;
        cc_data[t] <= '0;
      end
    end else begin
      grant_q       <= grant_d;
      grant_valid_q <= |grant_d;
      if (take) begin
        cc_hdr[pick]  <= cc_hdr[pick] + HDR_ONE;
        cc_data[pick] <= cc_data[pick] + need_data[pick];
        rr_q          <= next_type(pick);
      end
    end
  end

  // First update per type is InitFC (zero means infinite); an infinite
  // field stays infinite until reset.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      init_q         <= '0;
      hdr_inf        <= '0;
      data_inf       <= '0;
      fc_init_done_q <= 1'b0;
      for (int t = 0; t < 3; t++) begin
        cl_hdr[t]  <= '0;
        cl_data[t] <= '0;
      end
    end else begin
      for (int t = 0; t < 3; t++) begin
        if (upd_hit[t]) begin
          if (!init_q[t]) begin
            cl_hdr[t]   <= bus.fc_upd_hdr;
            cl_data[t]  <= bus.fc_upd_data;
            hdr_inf[t]  <= (bus.fc_upd_hdr == '0);
            data_inf[t] <= (bus.fc_upd_data == '0);
            init_q[t]   <= 1'b1;
          end else begin
            if (!hdr_inf[t])  cl_hdr[t]  <= bus.fc_upd_hdr;
            if (!data_inf[t]) cl_data[t] <= bus.fc_upd_data;
          end
        end
      end
      fc_init_done_q <= &init_d;
    end
  end

  assign bus.grant        = grant_q;
  assign bus.grant_valid  = grant_valid_q;
  assign bus.fc_init_done = fc_init_done_q;

endmodule

// File: tb/tb_tx_fc_arbiter.sv
// Bench for tx_fc_arbiter: directed scenarios plus a random run, all checked
// cycle by cycle against a credit/ordering reference model.
module tb_tx_fc_arbiter;
  localparam int HM = 4096;
  localparam int DM = 65536;

  logic clk = 1'b0;
  logic arst = 1'b0;
  always #5 clk = ~clk;

  tx_fc_arbiter_if bus ();
  tx_fc_arbiter dut (.clk(clk), .arst(arst), .bus(bus.slave));

  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int cl_h[3], cl_d[3], cc_h[3], cc_d[3];
  bit ini[3], inf_h[3], inf_d[3];
  bit m_done, m_ready;
  int m_busy;   // type currently owning the datapath, -1 when none
  int m_next;   // type that gets first look next time

  function automatic int data_need(bit hd, int l);
    int dw;
    if (!hd) return 0;
    dw = (l == 0) ? 1024 : l;
    return (dw + 3) / 4;
  endfunction

  function automatic bit fits(int cl, int cc, int need, int mod);
    return ((cl - cc - need) & (mod - 1)) <= mod / 2;
  endfunction

  task automatic model_reset();
    for (int t = 0; t < 3; t++) begin
      cl_h[t] = 0; cl_d[t] = 0; cc_h[t] = 0; cc_d[t] = 0;
      ini[t] = 0; inf_h[t] = 0; inf_d[t] = 0;
    end
    m_done = 0; m_ready = 0; m_busy = -1; m_next = 0;
  endtask

  task automatic model_step();
    bit rq[3], hd[3], ro[3], ok[3];
    int ln[3], nd[3];
    bit pblock, granted;
    int t, ut;
    rq = '{bus.p_req, bus.np_req, bus.cpl_req};
    hd = '{bus.p_has_data, bus.np_has_data, bus.cpl_has_data};
    ro = '{1'b1, bus.np_ro, bus.cpl_ro};
    ln = '{int'(bus.p_len), int'(bus.np_len), int'(bus.cpl_len)};
    for (int k = 0; k < 3; k++) begin
      nd[k] = data_need(hd[k], ln[k]);
      ok[k] = (inf_h[k] || fits(cl_h[k], cc_h[k], 1, HM)) &&
              (inf_d[k] || fits(cl_d[k], cc_d[k], nd[k], DM));
    end
    pblock = bus.p_req && !ok[0];
    if (m_busy >= 0) begin
      if (bus.tlp_done) m_busy = -1;
    end else if (m_ready) begin
      granted = 0;
      for (int k = 0; k < 3; k++) begin
        t = (m_next + k) % 3;
        if (!granted && rq[t] && ok[t] && (t == 0 || ro[t] || !pblock)) begin
          granted = 1;
          m_busy = t;
          cc_h[t] = (cc_h[t] + 1) % HM;
          cc_d[t] = (cc_d[t] + nd[t]) % DM;
          m_next = (t + 1) % 3;
        end
      end
    end
    m_ready = m_ready || m_done;
    if (bus.fc_upd_valid && bus.fc_upd_type != 2'd3) begin
      ut = int'(bus.fc_upd_type);
      if (!ini[ut]) begin
        ini[ut] = 1;
        cl_h[ut] = int'(bus.fc_upd_hdr);  inf_h[ut] = (bus.fc_upd_hdr == 0);
        cl_d[ut] = int'(bus.fc_upd_data); inf_d[ut] = (bus.fc_upd_data == 0);
      end else begin
        if (!inf_h[ut]) cl_h[ut] = int'(bus.fc_upd_hdr);
        if (!inf_d[ut]) cl_d[ut] = int'(bus.fc_upd_data);
      end
    end
    m_done = ini[0] && ini[1] && ini[2];
  endtask

  always @(posedge clk or posedge arst) begin
    if (arst) model_reset();
    else      model_step();
  end

  function automatic logic [2:0] model_grant();
    return (m_busy < 0) ? 3'b000 : 3'(1 << m_busy);
  endfunction

  // ---------------- stimulus ----------------
  bit auto_req, auto_done, auto_upd;
  int req_pct;

  task automatic raise_req(input int t, input bit hd, input logic [9:0] l, input bit ro);
    case (t)
      0: begin bus.p_has_data = hd; bus.p_len = l; bus.p_req = 1'b1; end
      1: begin bus.np_has_data = hd; bus.np_len = l; bus.np_ro = ro; bus.np_req = 1'b1; end
      default: begin bus.cpl_has_data = hd; bus.cpl_len = l; bus.cpl_ro = ro; bus.cpl_req = 1'b1; end
    endcase
  endtask

  function automatic bit req_of(input int t);
    return (t == 0) ? bus.p_req : (t == 1) ? bus.np_req : bus.cpl_req;
  endfunction

  task automatic tick();
    logic [9:0] l;
    @(negedge clk);
    if (!arst) begin
      check_val("cyc_grant", 32'(bus.grant), 32'(model_grant()));
      check_val("cyc_gv", 32'(bus.grant_valid), 32'(m_busy >= 0));
      check_val("cyc_init", 32'(bus.fc_init_done), 32'(m_done));
    end
    if (bus.grant[0]) bus.p_req = 1'b0;
    if (bus.grant[1]) bus.np_req = 1'b0;
    if (bus.grant[2]) bus.cpl_req = 1'b0;
    bus.tlp_done = auto_done && ((bus.grant_valid && $urandom_range(0, 2) == 0) ||
                                 (!bus.grant_valid && $urandom_range(0, 9) == 0));
    bus.fc_upd_valid = 1'b0;
    if (auto_upd && $urandom_range(0, 19) == 0) begin
      bus.fc_upd_valid = 1'b1;
      bus.fc_upd_type  = 2'($urandom_range(0, 3));
      bus.fc_upd_hdr   = 12'($urandom_range(0, 12));
      bus.fc_upd_data  = 16'($urandom_range(0, 300));
    end
    if (auto_req) begin
      for (int t = 0; t < 3; t++) begin
        if (!req_of(t) && !bus.grant[t] && $urandom_range(0, 99) < req_pct) begin
          l = ($urandom_range(0, 7) == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
          raise_req(t, 1'($urandom_range(0, 1)), l, 1'($urandom_range(0, 1)));
        end
      end
    end
  endtask

  task automatic send_upd(input int ty, input int h, input int d);
    bus.fc_upd_valid = 1'b1;
    bus.fc_upd_type  = 2'(ty);
    bus.fc_upd_hdr   = 12'(h);
    bus.fc_upd_data  = 16'(d);
    tick();
  endtask

  task automatic send_tlp(input int t, input bit hd, input int l, input bit ro);
    int n = 0;
    while ((req_of(t) || bus.grant[t]) && n < 300) begin tick(); n++; end
    raise_req(t, hd, 10'(l), ro);
  endtask

  task automatic wait_grant(input string tag, input logic [2:0] want);
    int n = 0;
    while (bus.grant !== want && n < 300) begin tick(); n++; end
    check_val(tag, 32'(bus.grant), 32'(want));
  endtask

  task automatic end_grant();
    bus.tlp_done = 1'b1;
    tick();
  endtask

  task automatic do_reset();
    auto_req = 0; auto_done = 0; auto_upd = 0; req_pct = 0;
    @(negedge clk);
    arst = 1'b1;
    bus.p_req = 0; bus.np_req = 0; bus.cpl_req = 0;
    bus.p_has_data = 0; bus.np_has_data = 0; bus.cpl_has_data = 0;
    bus.p_len = 0; bus.np_len = 0; bus.cpl_len = 0;
    bus.np_ro = 0; bus.cpl_ro = 0;
    bus.fc_upd_valid = 0; bus.fc_upd_type = 0; bus.fc_upd_hdr = 0; bus.fc_upd_data = 0;
    bus.tlp_done = 0;
    repeat (2) @(negedge clk);
    check_val("rst_grant", 32'(bus.grant), 32'd0);
    check_val("rst_gv", 32'(bus.grant_valid), 32'd0);
    check_val("rst_init", 32'(bus.fc_init_done), 32'd0);
    arst = 1'b0;
  endtask

  initial begin
    model_reset();
    do_reset();

    // InitFC sequence and first posted grant
    raise_req(0, 1'b1, 10'd125, 1'b0);
    send_upd(0, 10, 1000);
    send_upd(1, 10, 1000);
    check_val("t1_init_lo", 32'(bus.fc_init_done), 32'd0);
    send_upd(2, 10, 1000);
    check_val("t1_init_hi", 32'(bus.fc_init_done), 32'd1);
    tick();
    check_val("t1_not_yet", 32'(bus.grant), 32'd0);
    tick();
    check_val("t1_grant_p", 32'(bus.grant), 32'b001);
    repeat (3) tick();
    check_val("t1_hold", 32'(bus.grant), 32'b001);
    end_grant();
    check_val("t1_release", 32'(bus.grant), 32'd0);

    // Header credits exhausted, then replenished
    do_reset();
    send_upd(0, 2, 100);
    send_upd(1, 10, 1000);
    send_upd(2, 10, 1000);
    for (int i = 0; i < 2; i++) begin
      send_tlp(0, 1'b0, 0, 1'b0);
      wait_grant("t2_grant", 3'b001);
      end_grant();
    end
    send_tlp(0, 1'b0, 0, 1'b0);
    repeat (6) tick();
    check_val("t2_withheld", 32'(bus.grant), 32'd0);
    send_upd(0, 3, 100);
    wait_grant("t2_after_upd", 3'b001);
    end_grant();

    // Ordering: strict NP waits behind blocked P, relaxed CPL passes
    do_reset();
    send_upd(0, 10, 4);
    send_upd(1, 10, 1000);
    send_upd(2, 10, 1000);
    send_tlp(0, 1'b1, 16, 1'b0);
    wait_grant("t3_first_p", 3'b001);
    end_grant();
    raise_req(0, 1'b1, 10'd16, 1'b0);
    raise_req(1, 1'b0, 10'd0, 1'b0);
    raise_req(2, 1'b0, 10'd0, 1'b1);
    wait_grant("t3_cpl_only", 3'b100);
    end_grant();
    repeat (5) tick();
    check_val("t3_np_blocked", 32'(bus.grant), 32'd0);
    send_upd(0, 10, 8);
    wait_grant("t3_p_after_upd", 3'b001);
    end_grant();
    wait_grant("t3_np_last", 3'b010);
    end_grant();

    // Round robin with everything infinite and always requesting
    do_reset();
    send_upd(0, 0, 0);
    send_upd(1, 0, 0);
    send_upd(2, 0, 0);
    auto_req = 1; req_pct = 100;
    for (int i = 0; i < 9; i++) begin
      wait_grant($sformatf("t4_rr%0d", i), 3'(1 << (i % 3)));
      end_grant();
    end
    auto_req = 0;

    // Infinite CPL credits survive many max-size TLPs and later updates
    do_reset();
    send_upd(0, 10, 1000);
    send_upd(1, 10, 1000);
    send_upd(2, 0, 0);
    for (int i = 0; i < 300; i++) begin
      send_tlp(2, 1'b1, 0, 1'b1);
      wait_grant("t5_cpl", 3'b100);
      end_grant();
    end
    send_upd(2, 5, 5);
    for (int i = 0; i < 3; i++) begin
      send_tlp(2, 1'b1, 0, 1'b1);
      wait_grant("t5_cpl_after_upd", 3'b100);
      end_grant();
    end

    // Drive consumed P data credits up to 0xFFF0, then across the wrap
    do_reset();
    send_upd(1, 10, 1000);
    send_upd(2, 10, 1000);
    for (int i = 0; i < 255; i++) begin
      send_upd(0, 0, (i + 1) * 256);
      send_tlp(0, 1'b1, 0, 1'b0);
      wait_grant("t6_fill", 3'b001);
      end_grant();
    end
    for (int j = 0; j < 15; j++) begin
      send_upd(0, 0, 16'hFF00 + (j + 1) * 16);
      send_tlp(0, 1'b1, 64, 1'b0);
      wait_grant("t6_fill16", 3'b001);
      end_grant();
    end
    send_upd(0, 0, 16'h0010);
    send_tlp(0, 1'b1, 64, 1'b0);
    wait_grant("t6_wrap", 3'b001);
    end_grant();
    send_upd(0, 0, 16'h8010);
    send_tlp(0, 1'b1, 64, 1'b0);
    wait_grant("t6_half_ok", 3'b001);
    end_grant();
    send_upd(0, 0, 16'h8021);
    send_tlp(0, 1'b1, 64, 1'b0);
    repeat (6) tick();
    check_val("t6_half_over", 32'(bus.grant), 32'd0);
    send_upd(0, 0, 16'h0020);
    wait_grant("t6_resume", 3'b001);
    tick();
    #2 arst = 1'b1;
    #1;
    check_val("t6_arst_grant", 32'(bus.grant), 32'd0);
    check_val("t6_arst_gv", 32'(bus.grant_valid), 32'd0);
    check_val("t6_arst_init", 32'(bus.fc_init_done), 32'd0);

    // Random traffic, updates and stray tlp_done
    do_reset();
    for (int t = 0; t < 3; t++) send_upd(t, $urandom_range(0, 6), $urandom_range(0, 200));
    auto_req = 1; req_pct = 30; auto_done = 1; auto_upd = 1;
    repeat (4000) tick();
    auto_req = 0; auto_done = 0; auto_upd = 0;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tx_fc_arbiter.md
Name: tx_fc_arbiter

Overview:
Credit-gated TLP scheduler for the TL transmit side. It shares the single Tx datapath among three requesters: Posted (P), Non-Posted (NP) and Completion (CPL). It tracks link-partner flow-control credits per type (credit limit CL, credits consumed CC). A request is granted only when enough header and data credits are available and PCIe ordering allows it. It sits between the TLP source buffers and the Tx datapath/DLL interface, and is configured by the DLL InitFC/UpdateFC messages.

Parameters:
FC_HDR_WIDTH, 12, width of header credit counters (CL/CC), modular arithmetic
FC_DATA_WIDTH, 16, width of data credit counters (CL/CC), modular arithmetic
LEN_WIDTH, 10, TLP payload length field width in DW

Ports:
clk  in  1  clock
arst  in  1  asynchronous reset, active-high
p_req / np_req / cpl_req  in  1 each  request from P / NP / CPL source; held until granted
p_has_data / np_has_data / cpl_has_data  in  1 each  TLP carries payload
p_len / np_len / cpl_len  in  LEN_WIDTH each  payload length in DW; 0 encodes 1024
np_ro / cpl_ro  in  1 each  relaxed-ordering attribute of the pending NP/CPL TLP
fc_upd_valid  in  1  FC update strobe from DLL
fc_upd_type  in  2  0=P, 1=NP, 2=CPL, 3=ignored
fc_upd_hdr  in  FC_HDR_WIDTH  new header credit limit (absolute)
fc_upd_data  in  FC_DATA_WIDTH  new data credit limit (absolute)
tlp_done  in  1  datapath finished transmitting granted TLP
grant  out  3  one-hot {CPL,NP,P}, registered
grant_valid  out  1  OR of grant
fc_init_done  out  1  all three types initialised

Behaviour:
- Reset: grant=0, grant_valid=0, fc_init_done=0. All CL/CC=0. State=INIT. Round-robin pointer=P. Per-type init flags and infinite flags cleared.
- Asserting arst at any time, including mid-grant, immediately aborts the grant and returns the block to INIT.
- FC update: the first fc_upd_valid per type is InitFC. It sets CL and the init flag. A header value of 0 sets header-infinite; a data value of 0 sets data-infinite. Header and data are tracked independently.
- Later updates overwrite CL, except for infinite fields, which are ignored.
- A new CL takes effect on the cycle after fc_upd_valid. Arbitration on the same cycle uses the old CL.
- fc_init_done = AND of the three init flags (registered).
- Credit need: header = 1 credit. Data = 0 if has_data=0, else ceil(len_dw/4) (len=0 counts as 1024 DW, i.e. 256 credits).
- Eligibility per type, for each field: infinite, OR ((CL − (CC + need)) mod 2^W) ≤ 2^(W−1).
- Ordering:
  - NP or CPL with ro=0 is blocked while p_req=1 and P is not eligible (they may not pass posted).
  - P is never blocked by NP or CPL.
- FSM:
  - INIT → IDLE when fc_init_done=1.
  - IDLE: if any eligible unblocked request exists, pick one round-robin starting after the last granted type. Register the one-hot grant, update CC += need for that type (modular wrap), then go to GRANT.
  - GRANT: hold grant until tlp_done=1 is sampled; then clear grant and return to IDLE.
- Latency and spacing:
  - Minimum 1 IDLE cycle between successive grants.
  - Grant is asserted 1 cycle after req is sampled in IDLE.
  - A tlp_done asserted outside GRANT is ignored.
- Requester rules:
  - The source must hold req, len, has_data and ro stable until granted.
  - Dropping req while granted does not cancel the grant; only tlp_done ends it.
- CC wrap-around:
  - CC wraps modulo 2^W.
  - The check is modular, so it stays correct across wrap.
  - Exactly 2^(W−1) credits outstanding is still eligible.

Test Plan:
1. Reset, then InitFC P/NP/CPL each hdr=10 data=1000; p_req with len=125 → fc_init_done at cycle 4; grant=001 next cycle; CC_P_hdr=1, CC_P_data=32; grant held until tlp_done.
2. InitFC P hdr=2; issue 3 P TLPs with has_data=0 → first two granted, third withheld. UpdateFC P hdr=3 → third granted one cycle after the update takes effect.
3. P blocked (data CL exhausted), np_req with ro=0 and cpl_req with ro=1 → only CPL granted; after UpdateFC P, next grant is P, then NP.
4. All three continuously eligible and requesting → grant order P, NP, CPL, P, … with 1 idle cycle between grants.
5. InitFC CPL hdr=0 data=0 (infinite); 300 CPL grants of len=1024 → never blocked; later UpdateFC CPL hdr=5 ignored.
6. Preload CC_P_data=0xFFF0, CL=0x0010, need=16 → eligible, CC wraps to 0x0000. Assert arst during GRANT → grant=0 immediately, state INIT, fc_init_done=0.
